// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE datapath: opcodes, flag bit positions,
// writeback source selects and the writeback FSM state type.
package simple_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_CMP  = 4'b0101;
    localparam logic [3:0] OP_MOV  = 4'b0110;
    localparam logic [3:0] OP_RSV7 = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SLR  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_IN   = 4'b1100;
    localparam logic [3:0] OP_OUT  = 4'b1101;
    localparam logic [3:0] OP_RSVE = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_SFT,
        SRC_EXT
    } wb_src_e;

    typedef enum logic [1:0] {
        FLG_NONE,
        FLG_ALU,
        FLG_SFT
    } flag_src_e;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } wb_state_e;

endpackage

// File: rtl/exec_writeback_wb_select.sv
// wb_select: combinational opcode decode for writeback (also used by hazard unit).
// In: op. Out: write_en, data_sel, flag_sel, is_out, is_halt.
module wb_select
    import simple_pkg::*;
(
    input  logic [3:0] op,
    output logic       write_en,
    output wb_src_e    data_sel,
    output flag_src_e  flag_sel,
    output logic       is_out,
    output logic       is_halt
);

    always_comb begin
        write_en = 1'b0;
        data_sel = SRC_ALU;
        flag_sel = FLG_NONE;
        is_out   = 1'b0;
        is_halt  = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: begin
                write_en = 1'b1;
                flag_sel = FLG_ALU;
            end
            OP_CMP: flag_sel = FLG_ALU;
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
                write_en = 1'b1;
                data_sel = SRC_SFT;
                flag_sel = FLG_SFT;
            end
            OP_IN: begin
                write_en = 1'b1;
                data_sel = SRC_EXT;
            end
            OP_OUT:  is_out  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ; // reserved opcodes retire as NOP
        endcase
    end

endmodule

// File: rtl/exec_writeback.sv
// exec_writeback: writeback stage; registers RF write, SZCV flags, OUT port, halt.
// Ports: clk/rst, in_valid/in_ready, op/rd/results/flags/rs_data/ext_in in;
// wb_en/wb_addr/wb_data, flags, out_data/out_valid, halted out.
// Option WB_RETIRE_COUNT_EN adds a 32-bit `retired` accept counter.
module exec_writeback
    import simple_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [RW-1:0] rd,
    input  logic [DW-1:0] alu_result,
    input  logic [3:0]    alu_szcv,
    input  logic [DW-1:0] sft_result,
    input  logic [3:0]    sft_szcv,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] ext_in,
    output logic          wb_en,
    output logic [RW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic [3:0]    flags,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
`ifdef WB_RETIRE_COUNT_EN
    output logic [31:0]   retired,
`endif
    output logic          halted
);

    logic      write_en;
    wb_src_e   data_sel;
    flag_src_e flag_sel;
    logic      is_out;
    logic      is_halt;
    logic      accept;
    logic [DW-1:0] sel_data;
    wb_state_e state_q;
    wb_state_e state_d;

    wb_select u_sel (
        .op       (op),
        .write_en (write_en),
        .data_sel (data_sel),
        .flag_sel (flag_sel),
        .is_out   (is_out),
        .is_halt  (is_halt)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (accept && is_halt) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_RUN);
        halted   = (state_q == ST_HALTED);
    end

    always_comb begin
        sel_data = alu_result;
        unique case (data_sel)
            SRC_ALU: sel_data = alu_result;
            SRC_SFT: sel_data = sft_result;
            SRC_EXT: sel_data = ext_in;
            default: sel_data = alu_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            flags     <= 4'b0000;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            wb_en     <= accept && write_en;
            out_valid <= accept && is_out;
            if (accept && write_en) begin
                wb_addr <= rd;
                wb_data <= sel_data;
            end
            if (accept && flag_sel == FLG_ALU) flags <= alu_szcv;
            if (accept && flag_sel == FLG_SFT) flags <= sft_szcv;
            if (accept && is_out) out_data <= rs_data;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_q;

    // Counts every accept, NOPs and HALT included; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)         retire_q <= '0;
        else if (accept) retire_q <= retire_q + 32'd1;
    end

    assign retired = retire_q;
`endif

endmodule

// File: tb/tb_exec_writeback.sv
// Directed testbench for exec_writeback.
// Drives one instruction per step and checks registered outputs after the edge.
module tb_exec_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] alu_result;
    logic [3:0]  alu_szcv;
    logic [15:0] sft_result;
    logic [3:0]  sft_szcv;
    logic [15:0] rs_data;
    logic [15:0] ext_in;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  flags;
    logic [15:0] out_data;
    logic        out_valid;
    logic        halted;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exec_writeback #(.DW(16), .RW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rd         (rd),
        .alu_result (alu_result),
        .alu_szcv   (alu_szcv),
        .sft_result (sft_result),
        .sft_szcv   (sft_szcv),
        .rs_data    (rs_data),
        .ext_in     (ext_in),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flags      (flags),
        .out_data   (out_data),
        .out_valid  (out_valid),
`ifdef WB_RETIRE_COUNT_EN
        .retired    (retired),
`endif
        .halted     (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] o,
                         input logic [2:0] r);
        in_valid = v;
        op       = o;
        rd       = r;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 4'b0000, 3'd7);
        alu_result = 16'hFFFF; alu_szcv = 4'hF;
        sft_result = 16'hFFFF; sft_szcv = 4'hF;
        rs_data = 16'hFFFF; ext_in = 16'hFFFF;

        tick();
        check("rst_wb_en_c1", 32'(wb_en), 32'd0);
        tick();
        check("rst_wb_en_c2", 32'(wb_en), 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        rst = 1'b0;
        drive(1'b0, 4'b0000, 3'd7);
        tick();
        check("idle_wb_en", 32'(wb_en), 32'd0);

        drive(1'b1, 4'b0000, 3'd3);
        alu_result = 16'h1234; alu_szcv = 4'b0000;
        tick();
        check("add_wb_en", 32'(wb_en), 32'd1);
        check("add_wb_addr", 32'(wb_addr), 32'd3);
        check("add_wb_data", 32'(wb_data), 32'h1234);
        check("add_flags", 32'(flags), 32'h0);

        drive(1'b1, 4'b0101, 3'd6);
        alu_result = 16'hBEEF; alu_szcv = 4'b0100;
        tick();
        check("cmp_wb_en", 32'(wb_en), 32'd0);
        check("cmp_flags", 32'(flags), 32'h4);
        check("cmp_addr_hold", 32'(wb_addr), 32'd3);
        check("cmp_data_hold", 32'(wb_data), 32'h1234);

        drive(1'b1, 4'b1000, 3'd5);
        alu_result = 16'hFFFF; alu_szcv = 4'b1111;
        sft_result = 16'h8000; sft_szcv = 4'b1010;
        tick();
        check("sll_wb_en", 32'(wb_en), 32'd1);
        check("sll_wb_addr", 32'(wb_addr), 32'd5);
        check("sll_wb_data", 32'(wb_data), 32'h8000);
        check("sll_flags", 32'(flags), 32'hA);

        drive(1'b1, 4'b1100, 3'd2);
        ext_in = 16'h00A5; sft_szcv = 4'b0101;
        tick();
        check("in_wb_en", 32'(wb_en), 32'd1);
        check("in_wb_addr", 32'(wb_addr), 32'd2);
        check("in_wb_data", 32'(wb_data), 32'h00A5);
        check("in_flags", 32'(flags), 32'hA);

        drive(1'b1, 4'b1101, 3'd1);
        rs_data = 16'h5A5A;
        tick();
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_data", 32'(out_data), 32'h5A5A);
        check("out_wb_en", 32'(wb_en), 32'd0);
        check("out_flags", 32'(flags), 32'hA);

        drive(1'b0, 4'b1101, 3'd1);
        rs_data = 16'h1111;
        tick();
        check("out_pulse_end", 32'(out_valid), 32'd0);
        check("out_data_hold", 32'(out_data), 32'h5A5A);
        check("novalid_wb_en", 32'(wb_en), 32'd0);

        drive(1'b1, 4'b0000, 3'd1);
        alu_result = 16'h0001; alu_szcv = 4'b0001;
        tick();
        check("b2b1_wb_en", 32'(wb_en), 32'd1);
        check("b2b1_wb_data", 32'(wb_data), 32'h0001);
        drive(1'b1, 4'b0110, 3'd4);
        alu_result = 16'h0002; alu_szcv = 4'b0010;
        tick();
        check("b2b2_wb_en", 32'(wb_en), 32'd1);
        check("b2b2_wb_addr", 32'(wb_addr), 32'd4);
        check("b2b2_wb_data", 32'(wb_data), 32'h0002);
        check("b2b2_flags", 32'(flags), 32'h2);

        drive(1'b1, 4'b0111, 3'd6);
        alu_result = 16'h7777; alu_szcv = 4'b1101;
        tick();
        check("rsv7_wb_en", 32'(wb_en), 32'd0);
        check("rsv7_flags", 32'(flags), 32'h2);
        drive(1'b1, 4'b1110, 3'd6);
        tick();
        check("rsve_wb_en", 32'(wb_en), 32'd0);
        check("rsve_flags", 32'(flags), 32'h2);
        check("rsve_out_valid", 32'(out_valid), 32'd0);

        drive(1'b1, 4'b1111, 3'd0);
        tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_in_ready", 32'(in_ready), 32'd0);
        check("halt_wb_en", 32'(wb_en), 32'd0);

        drive(1'b1, 4'b0000, 3'd7);
        alu_result = 16'hDEAD; alu_szcv = 4'b1000;
        tick();
        check("halted_add_wb_en", 32'(wb_en), 32'd0);
        check("halted_add_flags", 32'(flags), 32'h2);
        drive(1'b1, 4'b1101, 3'd0);
        rs_data = 16'h2222;
        tick();
        check("halted_out_valid", 32'(out_valid), 32'd0);
        check("halted_out_data", 32'(out_data), 32'h5A5A);
        check("halted_sticky", 32'(halted), 32'd1);

        rst = 1'b1;
        drive(1'b1, 4'b0000, 3'd7);
        tick();
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        check("rst2_wb_en", 32'(wb_en), 32'd0);
        check("rst2_flags", 32'(flags), 32'd0);
        check("rst2_out_data", 32'(out_data), 32'd0);

        rst = 1'b0;
        drive(1'b1, 4'b0000, 3'd6);
        alu_result = 16'h0F0F; alu_szcv = 4'b0001;
        tick();
        check("run_again_wb_en", 32'(wb_en), 32'd1);
        check("run_again_wb_data", 32'(wb_data), 32'h0F0F);

`ifdef WB_RETIRE_COUNT_EN
        rst = 1'b1;
        drive(1'b0, 4'b0000, 3'd0);
        tick();
        rst = 1'b0;
        check("ret_reset", retired, 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i == 2) ? 4'b0111 : 4'b0101, 3'd0);
            tick();
            drive(1'b0, 4'b0000, 3'd0);
            tick();
            tick();
        end
        check("ret_five", retired, 32'd5);
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        check("ret_forced", retired, 32'hFFFF_FFFF);
        drive(1'b1, 4'b0000, 3'd1);
        tick();
        check("ret_wrap", retired, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_writeback.md
# exec_writeback

Writeback stage of the 16-bit SIMPLE datapath, directly downstream of the execute units (ALU and shifter). Each cycle it accepts one executed instruction and selects the ALU or shifter result by opcode. It registers the register-file write, maintains the architectural SZCV flag register, drives the output port for OUT, and enters a sticky halted state on HALT. Downstream consumers are the register file write port, the branch unit (reads `flags`) and the external output latch.

## Interface
Parameters:
- `DW`, 16, datapath width
- `RW`, 3, register address width (8 GPRs)

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock, all state updates on posedge
- `rst`  in  1  synchronous active-high reset
- `in_valid`  in  1  execute stage presents an instruction this cycle
- `in_ready`  out  1  stage accepts; equals `!halted`
- `op`  in  4  arithmetic/shift opcode field (same encoding as ALU/shifter: 0000 ADD … 1011 SRA, 1100 IN, 1101 OUT, 1111 HALT)
- `rd`  in  RW  destination register
- `alu_result`  in  DW  ALU result
- `alu_szcv`  in  4  ALU flags {S,Z,C,V}
- `sft_result`  in  DW  shifter result
- `sft_szcv`  in  4  shifter flags {S,Z,C,V}
- `rs_data`  in  DW  source operand, emitted by OUT
- `ext_in`  in  DW  external input, sampled by IN
- `wb_en`  out  1  register-file write strobe
- `wb_addr`  out  RW  write address
- `wb_data`  out  DW  write data
- `flags`  out  4  architectural {S,Z,C,V}
- `out_data`  out  DW  output port value, held between OUTs
- `out_valid`  out  1  one-cycle pulse on each OUT
- `halted`  out  1  sticky halt indicator

## Operation
- Accept condition is `in_valid && in_ready`. No accept: `wb_en` = 0, `out_valid` = 0, and the flags and `out_data` hold.
- Per-opcode behaviour on accept:
  - 0000–0100 (ADD/SUB/AND/OR/XOR) and 0110 (MOV): write `alu_result` to `rd`; `flags` ← `alu_szcv`.
  - 0101 CMP: no write; `flags` ← `alu_szcv`.
  - 1000–1011 (SLL/SLR/SRL/SRA): write `sft_result` to `rd`; `flags` ← `sft_szcv`.
  - 1100 IN: write `ext_in` to `rd`; flags unchanged.
  - 1101 OUT: no write; `out_data` ← `rs_data`; `out_valid` pulses; flags unchanged.
  - 0111, 1110 (reserved): NOP. No write, no flag change, no error.
  - 1111 HALT: no write; FSM goes RUN→HALTED.
- FSM states:
  - RUN: `in_ready` = 1.
  - HALTED: `in_ready` = 0, all inputs ignored. Only `rst` leaves HALTED (to RUN).
- Widths: results are passed through unmodified at DW bits. Flags are taken verbatim from the selected unit; this stage computes none.

## Timing
- Latency is 1 cycle. An instruction accepted at edge N drives `wb_en`/`wb_addr`/`wb_data` and `out_valid` during cycle N+1. `flags` and `out_data` show new values from edge N onward.
- `wb_en` and `out_valid` are single-cycle pulses per accepted instruction. Back-to-back accepts give back-to-back pulses, with no bubble.
- `wb_addr`/`wb_data` hold their last value when `wb_en` = 0.
- HALT accepted at edge N: `halted` = 1 and `in_ready` = 0 from N+1. `in_valid` at N+1 and later is dropped.
- Reset values: `wb_en` 0, `wb_addr` 0, `wb_data` 0, `flags` 0000, `out_data` 0, `out_valid` 0, `halted` 0, FSM RUN.
- `rst` together with `in_valid`: reset wins and the instruction is discarded. Reset mid-halt returns to RUN on the next cycle.

## Configuration
- `WB_RETIRE_COUNT_EN` defined:
  - Adds output `retired` (32 bits, reset 0).
  - Increments on every accepted instruction, including NOP, CMP, OUT and HALT.
  - Wraps from FFFF_FFFF to 0.
  - Updates on the same edge as the accept.
- Undefined: the port and counter do not exist; all other behaviour is identical.

## Structure
- Shared package `simple_pkg`: opcode localparams (OP_ADD … OP_HALT), flag bit indices (FLAG_S=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), FSM state typedef.
- One sub-module, `wb_select`: purely combinational. Maps opcode → {write_en, data_sel, flag_sel, is_out, is_halt}. It is reused by the hazard unit.

## Test plan
- **Reset.** Assert `rst` 2 cycles with `in_valid`=1 → all outputs at reset values, no `wb_en` pulse.
- **ADD/CMP.** Accept ADD rd=3, `alu_result`=0x1234, `alu_szcv`=0000, then CMP with `alu_szcv`=0100:
  - cycle N+1: `wb_en`=1, `wb_addr`=3, `wb_data`=0x1234.
  - CMP: `flags`=0100, no second `wb_en`.
- **Shift.** SLL rd=5 with `sft_result`=0x8000, `sft_szcv`=1010 → `wb_data`=0x8000, `flags`=1010. The ALU inputs (0xFFFF/1111) must be ignored.
- **IN then OUT.** `ext_in`=0x00A5 → r2 written with 0x00A5, flags unchanged. OUT with `rs_data`=0x5A5A → `out_valid` one cycle, `out_data` holds 0x5A5A after.
- **Reserved and HALT.** Op 0111 → no write, no flag change. HALT → `halted`=1, `in_ready`=0; following ADD is ignored. `rst` → RUN again.
- **Retire counter (`WB_RETIRE_COUNT_EN`).** 5 accepts with 2 idle cycles between → `retired`=5. Force 0xFFFF_FFFF, then one accept → `retired`=0.
